i2s_codec_master: RTL

I2S bus master for the WM8731 audio path. It generates BCLK and the shared DACLRC/ADCLRC frame clock from the 50 MHz system clock. It serialises a stereo sample pair onto ADCDAT and deserialises DACDAT into a stereo pair, using right-justified framing throughout. It is the other end of the codec-slave serial interface. It is used as the master when the FPGA owns the audio clocks, and as a bus-functional codec model in loopback benches.

---
 rtl/i2s_codec_master.sv | 123 ++++++++++++
 1 files changed

// File: rtl/i2s_codec_master.sv
// I2S bus master: divides clock_50m into BCLK and the shared LR frame clock,
// right-justified stereo serialiser on adcdat and deserialiser on dacdat.
module i2s_codec_master #(
  parameter int BCLK_DIV = 16,
  parameter int DATA_W   = 16
) (
  input  logic              clock_50m,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] tx_left,
  input  logic [DATA_W-1:0] tx_right,
  output logic              tx_req,
  output logic [DATA_W-1:0] rx_left,
  output logic [DATA_W-1:0] rx_right,
  output logic              rx_valid,
  output logic              bclk,
  output logic              daclrc,
  output logic              adclrc,
  output logic              adcdat,
  input  logic              dacdat
);
  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int PAD   = 32 - DATA_W;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;

  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        bit_cnt, bit_nxt;
  logic              primed;
  logic [63:0]       shreg, img;
  logic [DATA_W-1:0] acc_l, acc_r, acc_l_n, acc_r_n;
  logic              adv, term, rise_evt, fall_evt, wrap, in_data, rx_done;

  always_ff @(posedge clock_50m or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;

  always_comb state_n = enable ? RUN : IDLE;

  // Counting follows the next state so the first divider count lands on the
  // same edge that leaves IDLE; that gives BCLK_DIV cycles to the first rise.
  always_comb begin
    adv      = (state_n == RUN);
    term     = adv && (div_cnt == DIV_W'(BCLK_DIV - 1));
    rise_evt = term && !bclk;
    fall_evt = term && bclk;
    bit_nxt  = bit_cnt + 6'd1;
    wrap     = fall_evt && (bit_nxt == 6'd0);
    in_data  = ({1'b0, bit_cnt[4:0]} >= 6'(PAD));
    rx_done  = rise_evt && (bit_cnt == 6'd63) && primed;
    acc_l_n  = DATA_W'({acc_l, dacdat});
    acc_r_n  = DATA_W'({acc_r, dacdat});
    img      = {32'(tx_left), 32'(tx_right)};
  end

  assign adclrc = daclrc;

  always_ff @(posedge clock_50m or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      bit_cnt  <= 6'd63;
      bclk     <= 1'b0;
      daclrc   <= 1'b0;
      adcdat   <= 1'b0;
      shreg    <= '0;
      acc_l    <= '0;
      acc_r    <= '0;
      tx_req   <= 1'b0;
      rx_valid <= 1'b0;
    end else if (!adv) begin
      div_cnt  <= '0;
      bit_cnt  <= 6'd63;
      bclk     <= 1'b0;
      daclrc   <= 1'b0;
      adcdat   <= 1'b0;
      shreg    <= '0;
      acc_l    <= '0;
      acc_r    <= '0;
      tx_req   <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      tx_req   <= wrap;
      rx_valid <= rx_done;
      div_cnt  <= term ? '0 : div_cnt + 1'b1;
      if (term) bclk <= !bclk;
      if (fall_evt) begin
        bit_cnt <= bit_nxt;
        daclrc  <= !bit_nxt[5];
        // Zero-extended words make the leading pad bits fall out for free.
        if (wrap) begin
          shreg  <= {img[62:0], 1'b0};
          adcdat <= img[63];
        end else begin
          shreg  <= {shreg[62:0], 1'b0};
          adcdat <= shreg[63];
        end
      end
      if (rise_evt && in_data) begin
        if (bit_cnt[5]) acc_r <= acc_r_n;
        else            acc_l <= acc_l_n;
      end
    end
  end

  // Received pair holds across IDLE; only a fully primed frame updates it.
  always_ff @(posedge clock_50m or posedge reset) begin
    if (reset) begin
      rx_left  <= '0;
      rx_right <= '0;
    end else if (rx_done) begin
      rx_left  <= acc_l;
      rx_right <= acc_r_n;
    end
  end

  // Cleared for the whole IDLE stay, so a partial frame never counts.
  always_ff @(posedge clock_50m or posedge reset) begin
    if (reset)              primed <= 1'b0;
    else if (state == IDLE) primed <= 1'b0;
    else if (wrap)          primed <= 1'b1;
  end
endmodule
